vga_color_sequencer: RTL

//  Frame-synchronous colour scheduler sitting in front of vga_controller; drives its 9-bit sw input.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_color_sequencer_if.sv | 29 ++
 rtl/vga_frame_tick.sv | 23 ++
 rtl/vga_color_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA colour sequencer.
// Optional blanking between table entries is enabled by VGA_SEQ_BLANK_EN.
package vga_pkg;

  typedef logic [8:0] color_t;

  localparam color_t COLOR_BLACK   = 9'h000;
  localparam color_t COLOR_RED     = 9'h007;
  localparam color_t COLOR_GREEN   = 9'h038;
  localparam color_t COLOR_BLUE    = 9'h1C0;
  localparam color_t COLOR_YELLOW  = 9'h03F;
  localparam color_t COLOR_CYAN    = 9'h1F8;
  localparam color_t COLOR_MAGENTA = 9'h1C7;
  localparam color_t COLOR_WHITE   = 9'h1FF;

  localparam color_t DEFAULT_TABLE [8] = '{
    COLOR_BLACK, COLOR_RED, COLOR_GREEN, COLOR_BLUE,
    COLOR_YELLOW, COLOR_CYAN, COLOR_MAGENTA, COLOR_WHITE
  };

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    AUTO,
    BLANK
  } seq_state_t;

  // Tables deeper than 8 repeat the default palette.
  function automatic color_t default_color(input logic [2:0] i);
    return DEFAULT_TABLE[i];
  endfunction

endpackage

// File: rtl/vga_color_sequencer_if.sv
// Colour-table write port: valid/ready handshake, writer holds request until accepted.
// No configuration macros are used here.
interface vga_color_sequencer_if #(
  parameter int DEPTH = 8
) ();
  import vga_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  color_t           wr_data;
  logic             wr_ready;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/vga_frame_tick.sv
// Frame-start detector: registered one-cycle pulse on the falling edge of vsync.
// No configuration macros are used here.
module vga_frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic frame_tick
);

  logic vsync_q;

  // vsync_q resets high so a held-low vsync never produces a tick by itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vsync_q & ~vsync;
    end
  end

endmodule

// File: rtl/vga_color_sequencer.sv
// Frame-synchronous colour scheduler feeding vga_controller's sw input.
// Define VGA_SEQ_BLANK_EN to insert one black frame between auto-cycled entries.
//
// state  | meaning
// IDLE   | after reset, waiting for the first frame tick
// MANUAL | colour follows sw, sampled once per frame
// AUTO   | colour cycles through the table, FRAMES_PER_COLOR frames per entry
// BLANK  | one black frame before the next entry (VGA_SEQ_BLANK_EN only)
module vga_color_sequencer
  import vga_pkg::*;
#(
  parameter int DEPTH            = 8,
  parameter int FRAMES_PER_COLOR = 60
) (
  input  logic                     clk,
  input  logic                     rst,
  input  color_t                   sw,
  input  logic                     mode,
  input  logic                     vsync,
  vga_color_sequencer_if.slave     wr,
  output color_t                   color_cfg,
  output logic                     frame_tick,
  output logic [$clog2(DEPTH)-1:0] cur_idx
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FRAMES_PER_COLOR + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_COLOR - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] frame_cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  color_t           color_tbl [DEPTH];
  logic             rdy_q;
  logic             load_now;
  logic             wr_ready_int;
  logic             wr_accept;

  vga_frame_tick u_frame_tick (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  assign idx_next = idx + 1'b1;
  assign cur_idx  = idx;

  // True when the tick being processed this cycle reads the colour table.
  always_comb begin
    load_now = 1'b0;
    case (state)
      IDLE, MANUAL: load_now = mode;
`ifdef VGA_SEQ_BLANK_EN
      AUTO:         load_now = 1'b0;
      BLANK:        load_now = mode;
`else
      AUTO:         load_now = mode && (frame_cnt == CNT_LAST);
`endif
      default:      load_now = 1'b0;
    endcase
  end

  // Stalling writes on a load cycle keeps the loaded colour unambiguous.
  assign wr_ready_int = rdy_q & ~(frame_tick & load_now);
  assign wr.wr_ready  = wr_ready_int;
  assign wr_accept    = wr.wr_en & wr_ready_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      color_cfg <= COLOR_BLACK;
      frame_cnt <= '0;
      idx       <= '0;
      rdy_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        color_tbl[i] <= default_color(3'(i));
      end
    end else begin
      rdy_q <= 1'b1;

      if (wr_accept) begin
        color_tbl[wr.wr_addr] <= wr.wr_data;
      end

      if (frame_tick) begin
        case (state)
          IDLE, MANUAL: begin
            if (mode) begin
              state     <= AUTO;
              idx       <= '0;
              frame_cnt <= '0;
              color_cfg <= color_tbl[0];
            end else begin
              state     <= MANUAL;
              color_cfg <= sw;
            end
          end

          AUTO: begin
            if (!mode) begin
              state     <= MANUAL;
              color_cfg <= sw;
            end else if (frame_cnt != CNT_LAST) begin
              frame_cnt <= frame_cnt + 1'b1;
            end else begin
              frame_cnt <= '0;
              idx       <= idx_next;
`ifdef VGA_SEQ_BLANK_EN
              state     <= BLANK;
              color_cfg <= COLOR_BLACK;
`else
              color_cfg <= color_tbl[idx_next];
`endif
            end
          end

`ifdef VGA_SEQ_BLANK_EN
          // idx already points at the next entry; its hold time starts here.
          BLANK: begin
            if (!mode) begin
              state     <= MANUAL;
              color_cfg <= sw;
            end else begin
              state     <= AUTO;
              frame_cnt <= '0;
              color_cfg <= color_tbl[idx];
            end
          end
`endif

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
